// File: rtl/instr_mem_pkg.sv
// Shared types for the instruction memory responder:
// response bundle, grant FSM states, word width.
package instr_mem_pkg;

  localparam int WORD_W = 32;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [WORD_W-1:0] rdata;
  } instr_resp_t;

  typedef enum logic {
    GNT_IDLE,
    GNT_WAIT
  } gnt_state_e;

endpackage

// File: rtl/instr_resp_pipe.sv
// Fixed-latency delay line for fetch responses.
// Every stage clears on reset, dropping in-flight responses.
module instr_resp_pipe
  import instr_mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  instr_resp_t din,
  output instr_resp_t dout
);

  instr_resp_t stage_q [LATENCY];

  // shift one response per cycle toward the output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[LATENCY-1];

endmodule

// File: rtl/instr_mem_responder.sv
// Memory side of the instruction fetch port.
// Optional per-word parity: INSTR_RESP_PARITY_EN.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE     = 32'h0,
  parameter int          MEM_DEPTH    = 1024,
  parameter int          GNT_WAIT     = 0,
  parameter int          RESP_LATENCY = 1,
  localparam int         AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          instr_req_i,
  output logic          instr_gnt_o,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
`ifdef INSTR_RESP_PARITY_EN
  input  logic          load_inj_i,
`endif
  input  logic [31:0]   load_wdata_i
);

`ifdef INSTR_RESP_PARITY_EN
  localparam int MEM_W = WORD_W + 1;
`else
  localparam int MEM_W = WORD_W;
`endif

  localparam logic [3:0] WAIT_N = 4'(GNT_WAIT);

  gnt_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt;

  // grant FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= instr_mem_pkg::GNT_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // count held-request cycles; abort on dropped req
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (GNT_WAIT != 0) begin
      unique case (state_q)
        instr_mem_pkg::GNT_IDLE: begin
          if (instr_req_i) begin
            state_d = instr_mem_pkg::GNT_WAIT;
            cnt_d   = 4'd1;
          end
        end
        instr_mem_pkg::GNT_WAIT: begin
          if (!instr_req_i || cnt_q == WAIT_N) begin
            state_d = instr_mem_pkg::GNT_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  // grant: pass-through with no wait, else end of count
  always_comb begin
    gnt = 1'b0;
    if (GNT_WAIT == 0) begin
      gnt = instr_req_i;
    end else begin
      gnt = instr_req_i
          & (state_q == instr_mem_pkg::GNT_WAIT)
          & (cnt_q == WAIT_N);
    end
  end

  assign instr_gnt_o = gnt & rst_ni;

  logic [32:0] addr_x, base_x, lim_x;
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic addr_err;
  logic unused_off;

  assign addr_x = {1'b0, instr_addr_i};
  assign base_x = {1'b0, MEM_BASE};
  assign lim_x  = base_x + (33'(MEM_DEPTH) << 2);
  assign off    = instr_addr_i - MEM_BASE;
  assign idx    = off[AW+1:2];
  assign unused_off = ^{off[31:AW+2], off[1:0]};

  assign addr_err = (instr_addr_i[1:0] != 2'b00)
                  | (addr_x < base_x)
                  | (addr_x >= lim_x);

  logic [MEM_W-1:0] mem [MEM_DEPTH];
  logic [MEM_W-1:0] wr_word, rd_word;
  logic par_err;

`ifdef INSTR_RESP_PARITY_EN
  assign wr_word = {^load_wdata_i ^ load_inj_i,
                    load_wdata_i};
  assign par_err = ^rd_word;
`else
  assign wr_word = load_wdata_i;
  assign par_err = 1'b0;
`endif

  // array write; a same-cycle fetch still reads old data
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= wr_word;
    end
  end

  assign rd_word = mem[idx];

  logic        fetch_err;
  instr_resp_t resp_d, resp_q;

  assign fetch_err = addr_err | par_err;

  // build the response; fields stay 0 when not valid
  always_comb begin
    resp_d       = '0;
    resp_d.valid = instr_gnt_o;
    resp_d.err   = instr_gnt_o & fetch_err;
    if (instr_gnt_o && !fetch_err) begin
      resp_d.rdata = rd_word[WORD_W-1:0];
    end
  end

  instr_resp_pipe #(
    .LATENCY (RESP_LATENCY)
  ) u_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .din    (resp_d),
    .dout   (resp_q)
  );

  assign instr_rvalid_o = resp_q.valid;
  assign instr_err_o    = resp_q.err;
  assign instr_rdata_o  = resp_q.rdata;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder.
// Three instances: wait/latency mixes.
module tb_instr_mem_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        load_we;
  logic [3:0]  load_addr;
  logic [31:0] load_wdata;
`ifdef INSTR_RESP_PARITY_EN
  logic        load_inj;
`endif

  logic req_a, gnt_a, rv_a, er_a;
  logic req_b, gnt_b, rv_b, er_b;
  logic req_c, gnt_c, rv_c, er_c;
  logic [31:0] addr_a, rd_a;
  logic [31:0] addr_b, rd_b;
  logic [31:0] addr_c, rd_c;

  instr_mem_responder #(
    .MEM_BASE(BASE), .MEM_DEPTH(DEPTH),
    .GNT_WAIT(0), .RESP_LATENCY(1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(req_a), .instr_gnt_o(gnt_a),
    .instr_addr_i(addr_a), .instr_rvalid_o(rv_a),
    .instr_rdata_o(rd_a), .instr_err_o(er_a),
    .load_we_i(load_we), .load_addr_i(load_addr),
`ifdef INSTR_RESP_PARITY_EN
    .load_inj_i(load_inj),
`endif
    .load_wdata_i(load_wdata)
  );

  instr_mem_responder #(
    .MEM_BASE(BASE), .MEM_DEPTH(DEPTH),
    .GNT_WAIT(2), .RESP_LATENCY(2)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(req_b), .instr_gnt_o(gnt_b),
    .instr_addr_i(addr_b), .instr_rvalid_o(rv_b),
    .instr_rdata_o(rd_b), .instr_err_o(er_b),
    .load_we_i(load_we), .load_addr_i(load_addr),
`ifdef INSTR_RESP_PARITY_EN
    .load_inj_i(load_inj),
`endif
    .load_wdata_i(load_wdata)
  );

  instr_mem_responder #(
    .MEM_BASE(BASE), .MEM_DEPTH(DEPTH),
    .GNT_WAIT(0), .RESP_LATENCY(3)
  ) dut_c (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(req_c), .instr_gnt_o(gnt_c),
    .instr_addr_i(addr_c), .instr_rvalid_o(rv_c),
    .instr_rdata_o(rd_c), .instr_err_o(er_c),
    .load_we_i(load_we), .load_addr_i(load_addr),
`ifdef INSTR_RESP_PARITY_EN
    .load_inj_i(load_inj),
`endif
    .load_wdata_i(load_wdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        err;
    logic [31:0] data;
  } vec_t;

  vec_t vt [8];
  int total = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] word_init(int i);
    if (i == 0) return 32'hDEADBEEF;
    return 32'hA500_0000 + 32'(i);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    vt[0] = '{BASE,            1'b0, 32'hDEADBEEF};
    vt[1] = '{BASE + 32'h4,    1'b0, 32'hA5000001};
    vt[2] = '{BASE + 32'h3C,   1'b0, 32'hA500000F};
    vt[3] = '{BASE + 32'h2,    1'b1, 32'h0};
    vt[4] = '{BASE - 32'h4,    1'b1, 32'h0};
    vt[5] = '{BASE + 32'h40,   1'b1, 32'h0};
    vt[6] = '{32'hFFFF_FFFC,   1'b1, 32'h0};
    vt[7] = '{BASE + 32'h1,    1'b1, 32'h0};

    rst_n = 1'b0;
    load_we = 1'b0; load_addr = '0; load_wdata = '0;
`ifdef INSTR_RESP_PARITY_EN
    load_inj = 1'b0;
`endif
    req_a = 1'b0; addr_a = '0;
    req_b = 1'b0; addr_b = '0;
    req_c = 1'b0; addr_c = '0;

    @(negedge clk);
    #1;
    chk("rst_a", {gnt_a, rv_a, er_a}, 32'h0);
    chk("rst_a_rd", rd_a, 32'h0);
    chk("rst_b", {gnt_b, rv_b, er_b}, 32'h0);
    chk("rst_c", {gnt_c, rv_c, er_c}, 32'h0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      load_we = 1'b1;
      load_addr = 4'(i);
      load_wdata = word_init(i);
      step();
    end
    load_we = 1'b0;

    // table: single fetches on the zero-wait instance
    for (int i = 0; i < 8; i++) begin
      req_a = 1'b1;
      addr_a = vt[i].addr;
      #1;
      chk($sformatf("a_gnt%0d", i), gnt_a, 1);
      step();
      chk($sformatf("a_rv%0d", i), rv_a, 1);
      chk($sformatf("a_err%0d", i), er_a, vt[i].err);
      chk($sformatf("a_rd%0d", i), rd_a, vt[i].data);
      req_a = 1'b0;
      step();
      chk($sformatf("a_idle%0d", i),
          {rv_a, er_a}, 32'h0);
      chk($sformatf("a_idle_rd%0d", i), rd_a, 0);
    end

    // two-cycle grant wait, held request
    req_b = 1'b1;
    addr_b = BASE + 32'h4;
    #1; chk("b_gnt_c1", gnt_b, 0);
    step(); chk("b_gnt_c2", gnt_b, 0);
    step(); chk("b_gnt_c3", gnt_b, 1);
    chk("b_rv_c3", rv_b, 0);
    step();
    req_b = 1'b0;
    #1; chk("b_gnt_c4", gnt_b, 0);
    chk("b_rv_c4", rv_b, 0);
    step();
    chk("b_rv_c5", rv_b, 1);
    chk("b_rd_c5", rd_b, 32'hA5000001);
    chk("b_err_c5", er_b, 0);
    step();
    chk("b_rv_c6", rv_b, 0);

    // abort in cycle 2
    req_b = 1'b1;
    addr_b = BASE + 32'h8;
    #1; chk("ab_gnt1", gnt_b, 0);
    step();
    req_b = 1'b0;
    #1; chk("ab_gnt2", gnt_b, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("ab_quiet%0d", k),
          {gnt_b, rv_b}, 32'h0);
    end
    req_b = 1'b1;
    #1; chk("ab_re1", gnt_b, 0);
    step(); chk("ab_re2", gnt_b, 0);
    step(); chk("ab_re3", gnt_b, 1);
    step();
    req_b = 1'b0;
    #1; chk("ab_rv1", rv_b, 0);
    step();
    chk("ab_rv2", rv_b, 1);
    chk("ab_rd2", rd_b, 32'hA5000002);

    // four back-to-back grants, latency 3
    for (int k = 0; k < 8; k++) begin
      req_c = (k < 4);
      addr_c = BASE + 32'(4 * k);
      #1;
      chk($sformatf("c_gnt%0d", k), gnt_c, (k < 4));
      chk($sformatf("c_rv%0d", k), rv_c,
          (k >= 3 && k < 7));
      if (k >= 3 && k < 7)
        chk($sformatf("c_rd%0d", k), rd_c,
            word_init(k - 3));
      else
        chk($sformatf("c_rd%0d", k), rd_c, 0);
      step();
    end

    // reset after the second grant
    req_c = 1'b1; addr_c = BASE;
    step();
    addr_c = BASE + 32'h4;
    step();
    req_c = 1'b0;
    step();
    chk("cr_rv_pre", rv_c, 1);
    chk("cr_rd_pre", rd_c, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("cr_rv_rst", {gnt_c, rv_c, er_c}, 32'h0);
    chk("cr_rd_rst", rd_c, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("cr_quiet%0d", k), rv_c, 0);
    end

    // load and fetch of word 5 in the same cycle
    load_we = 1'b1; load_addr = 4'd5;
    load_wdata = 32'h1;
    req_a = 1'b1; addr_a = BASE + 32'h14;
    step();
    load_we = 1'b0; req_a = 1'b0;
    chk("col_rv", rv_a, 1);
    chk("col_old", rd_a, 32'hA5000005);
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    chk("col_new", rd_a, 32'h1);
    chk("col_err", er_a, 0);

`ifdef INSTR_RESP_PARITY_EN
    load_we = 1'b1; load_addr = 4'd7;
    load_wdata = 32'h77; load_inj = 1'b1;
    step();
    load_we = 1'b0; load_inj = 1'b0;
    req_a = 1'b1; addr_a = BASE + 32'h1C;
    step();
    req_a = 1'b0;
    chk("par_err", er_a, 1);
    chk("par_rd", rd_a, 0);
    load_we = 1'b1;
    step();
    load_we = 1'b0;
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    chk("par_ok_err", er_a, 0);
    chk("par_ok_rd", rd_a, 32'h77);
`endif

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
